unpack_rq0: RTL and testbench
=============================

Name: unpack_rq0

Overview:
- Encaps-path stage that deserialises a packed Rq0 polynomial byte stream into 13-bit coefficients, one per handshake, for the downstream mod-2^13 add stage.
- Emits the N-1 explicit coefficients, then a reconstructed final coefficient c[N-1] = (-sum of c[0..N-2]) mod 2^13.
- Sits between the byte-level input buffer and the coefficient adder.

Parameters:
- N, 701, polynomial length; N-1 coefficients are packed.
- Q_BITS, 13, coefficient width (q = 2^13).
- IN_W, 8, input word width in bits.
- IDX_W, 10, coefficient index width; must satisfy 2^IDX_W >= N.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- start  input  1  one-cycle pulse; begins unpacking a polynomial.
- busy  output  1  high from the cycle after an accepted start until done.
- in_data  input  IN_W  packed byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- coef  output  Q_BITS  coefficient value.
- coef_idx  output  IDX_W  coefficient index, 0..N-1.
- coef_valid  output  1  coef/coef_idx valid.
- coef_ready  input  1  coefficient consumed when coef_valid && coef_ready.
- done  output  1  one-cycle pulse after the last coefficient handshake.

Behaviour:
- Clocking/reset: single clock clk. rst is synchronous, active-high.
- Reset values: FSM goes to IDLE; busy, in_ready, coef_valid and done are 0; coef, coef_idx, bit buffer, fill count, byte count and accumulator are 0.
- rst mid-operation aborts immediately. Partial data is discarded and no done pulse is produced.
- Packing: little-endian bitstream. Coefficient i occupies stream bits 13i..13i+12, LSB first. Byte k supplies stream bits 8k..8k+7.
- Total input is ceil((N-1)*13/8) = 1138 bytes. The 4 pad bits in the top of the last byte are discarded.
- FSM states:
  - IDLE: start=1 moves to RUN and clears counters and accumulator. start is ignored outside IDLE.
  - RUN:
    - in_ready = (fill < 13) && (bytes_taken < 1138).
    - On an accepted byte, the byte is shifted into buffer bits [fill +: 8] and fill += 8. The buffer is 20 bits wide.
    - coef_valid = (fill >= 13). coef = buffer[12:0]; coef_idx = count of emitted coefficients.
    - On a coefficient handshake: buffer >>= 13, fill -= 13, acc = (acc + coef) mod 2^13.
    - in_ready and coef_valid are mutually exclusive by construction, so no same-cycle accept+emit occurs.
    - After handshake of coefficient N-2: go to LAST and drop any remaining pad bits.
  - LAST: coef_valid=1, coef = (~acc + 1) mod 2^13, coef_idx = N-1, in_ready=0. On handshake, go to DONE.
  - DONE: done=1 for one cycle, busy=0 from this cycle, then IDLE.
- Outputs are registered or derived only from registered state. No combinational path from coef_ready to in_ready.
- Backpressure: while coef_valid && !coef_ready, coef and coef_idx hold stable.
- Latency: in_ready rises the cycle after start. The first coef_valid is asserted 2 cycles after the second accepted byte.
- busy=0 in IDLE; in_ready and coef_valid stay 0 in IDLE and DONE.

Decomposition:
- Shared package rq0_pkg:
  - constants N, Q_BITS, PACKED_BYTES=1138, PAD_BITS=4;
  - enum state_t {IDLE, RUN, LAST, DONE};
  - typedef coef_t = logic[12:0].
- Natural sub-module: unpack_bitbuf. It holds the 20-bit buffer and fill counter, takes push/pop strobes, and exposes fill and buffer[12:0].
- FSM, counters and accumulator live in the top module.

Test Plan:
- All-zero stream, coef_ready tied 1 -> 701 coefficients, all 0. Indices 0..700 in order, done once, exactly 1138 bytes accepted.
- All-0xFF stream -> c[0..699] = 8191. c[700] = 700, since sum = -700 mod 8192.
- Bytes 0x01,0x20 then zeros -> c[0]=1, c[1]=1, c[2..699]=0, c[700]=8190.
- Random stream with random in_valid gaps and random coef_ready stalls -> output matches a software unpack_Rq0 model. coef is stable during every stall. in_ready and coef_valid are never both high.
- rst asserted at coefficient 300, then a new start with zero stream -> no done from the aborted run. The new run starts at idx 0 with acc cleared, and c[700]=0.
- start pulsed while busy -> ignored. No count reset, identical output to an undisturbed run.

Source files
------------

// File: rtl/rq0_pkg.sv
// rtl/rq0_pkg.sv - shared constants, types and helpers for the Rq0 unpack stage
// Purpose: polynomial geometry, bit-buffer sizing, FSM state type and the
//          mod-2^13 negation used to rebuild the final coefficient.
// Ports:   none (package).
package rq0_pkg;

  localparam int N            = 701;
  localparam int Q_BITS       = 13;
  localparam int IN_W         = 8;
  localparam int IDX_W        = 10;
  localparam int PAD_BITS     = 4;
  localparam int PACKED_BYTES = ((N - 1) * Q_BITS + PAD_BITS) / IN_W;

  // Buffer must hold a partial coefficient (up to Q_BITS-1 bits) plus one new byte.
  localparam int BUF_W  = Q_BITS + IN_W - 1;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int BYTE_W = $clog2(PACKED_BYTES + 1);

  typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_t;

  typedef logic [Q_BITS-1:0] coef_t;

  // Two's-complement negation wraps naturally at Q_BITS, giving (-a) mod 2^13.
  function automatic coef_t neg_mod_q(input coef_t a);
    return ~a + 1'b1;
  endfunction

endpackage

// File: rtl/unpack_bitbuf.sv
// rtl/unpack_bitbuf.sv - little-endian bit accumulator feeding the coefficient extractor
// Purpose: collects input bytes above the currently held bits and releases
//          Q_BITS-wide chunks from the bottom.
// Ports:   clk, rst        clock, synchronous active-high reset
//          clr             discard all held bits
//          push, push_data append a byte at bit position fill
//          pop             drop the low Q_BITS bits
//          fill            number of valid bits held
//          low             buffer[Q_BITS-1:0]
module unpack_bitbuf
  import rq0_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [IN_W-1:0]   push_data,
  input  logic              pop,
  output logic [FILL_W-1:0] fill,
  output logic [Q_BITS-1:0] low
);

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Bits at and above fill are always zero, so a byte can be OR-ed in place.
  // If pop and push coincide, the byte lands above the post-pop fill level.
  always_comb begin
    buf_d  = buf_q;
    fill_d = fill_q;
    if (pop) begin
      buf_d  = buf_q >> Q_BITS;
      fill_d = fill_q - FILL_W'(Q_BITS);
    end
    if (push) begin
      buf_d  = buf_d | (BUF_W'(push_data) << fill_d);
      fill_d = fill_d + FILL_W'(IN_W);
    end
    if (clr) begin
      buf_d  = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;
  assign low  = buf_q[Q_BITS-1:0];

endmodule

// File: rtl/unpack_rq0.sv
// rtl/unpack_rq0.sv - deserialises a packed Rq0 polynomial into 13-bit coefficients
// Purpose: emits N-1 explicit coefficients from the byte stream, then the
//          reconstructed last one, c[N-1] = -(sum c[0..N-2]) mod 2^13.
// Ports:   clk, rst                       clock, synchronous active-high reset
//          start, busy, done              job control (done is a one-cycle pulse)
//          in_data, in_valid, in_ready    packed byte input handshake
//          coef, coef_idx, coef_valid,
//          coef_ready                     coefficient output handshake
module unpack_rq0
  import rq0_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [Q_BITS-1:0] coef,
  output logic [IDX_W-1:0]  coef_idx,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              done
);

  localparam logic [FILL_W-1:0] FILL_COEF = FILL_W'(Q_BITS);
  localparam logic [BYTE_W-1:0] BYTES_MAX = BYTE_W'(PACKED_BYTES);
  localparam logic [IDX_W-1:0]  IDX_PEN   = IDX_W'(N - 2);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   bytes_q;
  coef_t               acc_q;
  coef_t               coef_q;
  logic [IDX_W-1:0]    idx_q;
  logic                valid_q;

  logic [FILL_W-1:0]   fill;
  coef_t               low;
  logic                push, pop, clr, hs, last_pop;

  // Output stage is a register: a coefficient is loaded only while nothing is
  // on offer, and the bit buffer pops in the same cycle as the handshake.
  assign hs       = valid_q && coef_ready;
  assign in_ready = (state_q == RUN) && !valid_q && (fill < FILL_COEF) && (bytes_q < BYTES_MAX);
  assign push     = in_valid && in_ready;
  assign pop      = hs && (state_q == RUN);
  assign last_pop = pop && (idx_q == IDX_PEN);
  // Clearing on the final pop discards the pad bits of the last byte.
  assign clr      = ((state_q == IDLE) && start) || last_pop;

  unpack_bitbuf u_bitbuf (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .fill      (fill),
    .low       (low)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_pop) state_d = LAST;
      LAST:    if (hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bytes_q <= '0;
      acc_q   <= '0;
      coef_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            bytes_q <= '0;
            acc_q   <= '0;
            coef_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
          end
        end
        RUN: begin
          if (push) bytes_q <= bytes_q + 1'b1;
          if (hs) begin
            acc_q <= acc_q + coef_q;
            if (idx_q == IDX_PEN) begin
              // Present the reconstructed coefficient straight away in LAST.
              valid_q <= 1'b1;
              coef_q  <= neg_mod_q(acc_q + coef_q);
              idx_q   <= IDX_LAST;
            end else begin
              valid_q <= 1'b0;
              idx_q   <= idx_q + 1'b1;
            end
          end else if (!valid_q && (fill >= FILL_COEF)) begin
            valid_q <= 1'b1;
            coef_q  <= low;
          end
        end
        LAST: begin
          if (hs) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q == RUN) || (state_q == LAST);
  assign done       = (state_q == DONE);
  assign coef       = coef_q;
  assign coef_idx   = idx_q;
  assign coef_valid = valid_q;

endmodule

// File: tb/tb_unpack_rq0.sv
// tb/tb_unpack_rq0.sv - directed self-checking bench for unpack_rq0
module tb_unpack_rq0;
  import rq0_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start, busy, in_valid, in_ready;
  logic              coef_valid, coef_ready, done;
  logic [IN_W-1:0]   in_data;
  logic [Q_BITS-1:0] coef;
  logic [IDX_W-1:0]  coef_idx;

  always #5 clk = ~clk;

  unpack_rq0 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coef       (coef),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .done       (done)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  stream [PACKED_BYTES];
  logic [12:0] expc [N];
  logic [12:0] got  [N];
  int          lat;
  int          aborted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-level reference: coefficient i is stream bits 13i..13i+12, LSB first.
  task automatic build_model();
    int          sum;
    int          bp;
    logic [12:0] c;
    sum = 0;
    for (int i = 0; i < N - 1; i++) begin
      c = '0;
      for (int b = 0; b < 13; b++) begin
        bp   = 13 * i + b;
        c[b] = stream[bp / 8][bp % 8];
      end
      expc[i] = c;
      sum += int'(c);
    end
    expc[N-1] = 13'(-sum);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int k = 0; k < PACKED_BYTES; k++) stream[k] = v;
    build_model();
  endtask

  task automatic fill_rand();
    for (int k = 0; k < PACKED_BYTES; k++) stream[k] = 8'($urandom_range(255));
    build_model();
  endtask

  task automatic run(input int gap_pct, input int stall_pct, input int abort_at,
                     input int restart_cyc, output int latency, output int was_aborted);
    int          bi, ci, cyc, acc2, first_v;
    bit          finished, stalled;
    logic [12:0] hold_c;
    logic [9:0]  hold_i;
    bi = 0; ci = 0; cyc = 0; acc2 = -1; first_v = -1;
    finished = 0; stalled = 0; was_aborted = 0;
    hold_c = '0; hold_i = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("in_ready_after_start", in_ready, 1);
    check("busy_after_start", busy, 1);
    while (!finished && was_aborted == 0 && cyc < 20000) begin
      check("ready_valid_exclusive", in_ready & coef_valid, 0);
      if (stalled) begin
        check("stall_valid_held", coef_valid, 1);
        check("stall_coef_stable", coef, hold_c);
        check("stall_idx_stable", coef_idx, hold_i);
      end
      if (done) begin
        check("done_coef_count", ci, N);
        check("done_byte_count", bi, PACKED_BYTES);
        check("busy_low_at_done", busy, 0);
        finished = 1;
      end else if (abort_at >= 0 && coef_valid && int'(coef_idx) == abort_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        was_aborted = 1;
      end else begin
        start = (cyc == restart_cyc);
        coef_ready = ($urandom_range(99) >= stall_pct);
        if (coef_valid && first_v < 0) first_v = cyc;
        if (coef_valid && coef_ready) begin
          if (ci < N) begin
            check("coef_value", coef, expc[ci]);
            check("coef_index", coef_idx, ci);
            got[ci] = coef;
          end else begin
            check("coef_overrun", ci, N - 1);
          end
          ci++;
        end
        stalled = coef_valid && !coef_ready;
        hold_c  = coef;
        hold_i  = coef_idx;
        if (bi < PACKED_BYTES && $urandom_range(99) >= gap_pct) begin
          in_valid = 1'b1;
          in_data  = stream[bi];
        end else begin
          in_valid = 1'b0;
          in_data  = '0;
        end
        if (in_valid && in_ready) begin
          bi++;
          if (bi == 2) acc2 = cyc;
        end
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    coef_ready = 1'b0;
    if (was_aborted == 0) begin
      check("run_completed", finished, 1);
      tick();
      check("done_one_cycle", done, 0);
      check("idle_in_ready", in_ready, 0);
      check("idle_coef_valid", coef_valid, 0);
    end
    latency = first_v - acc2;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; coef_ready = 1'b0;
    tick(); tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_coef_valid", coef_valid, 0);
    check("rst_done", done, 0);
    check("rst_coef", coef, 0);
    check("rst_coef_idx", coef_idx, 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready_no_start", in_ready, 0);

    fill_const(8'h00);
    run(0, 0, -1, -1, lat, aborted);
    check("first_valid_latency", lat, 2);
    check("zero_c0", got[0], 0);
    check("zero_c700", got[700], 0);

    fill_const(8'hFF);
    run(0, 0, -1, -1, lat, aborted);
    check("ff_c0", got[0], 8191);
    check("ff_c699", got[699], 8191);
    check("ff_c700", got[700], 700);

    for (int k = 0; k < PACKED_BYTES; k++) stream[k] = 8'h00;
    stream[0] = 8'h01;
    stream[1] = 8'h20;
    build_model();
    run(0, 0, -1, -1, lat, aborted);
    check("one_c0", got[0], 1);
    check("one_c1", got[1], 1);
    check("one_c2", got[2], 0);
    check("one_c700", got[700], 8190);

    fill_rand();
    run(30, 40, -1, -1, lat, aborted);

    fill_const(8'hFF);
    run(10, 10, 300, -1, lat, aborted);
    check("abort_taken", aborted, 1);
    check("abort_busy", busy, 0);
    check("abort_coef_valid", coef_valid, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_coef_idx", coef_idx, 0);
    check("abort_no_done", done, 0);
    fill_const(8'h00);
    run(0, 0, -1, -1, lat, aborted);
    check("after_abort_c700", got[700], 0);

    fill_rand();
    run(0, 20, -1, 40, lat, aborted);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
